// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 800x600@60 raster constants and coordinate type
package vga_timing_pkg;

    localparam int unsigned COORD_W = 11;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int unsigned VGA_H_SYNC = 128;
    localparam int unsigned VGA_H_BP   = 88;
    localparam int unsigned VGA_H_ACT  = 800;
    localparam int unsigned VGA_H_FP   = 40;
    localparam int unsigned VGA_H_TOT  = VGA_H_SYNC + VGA_H_BP + VGA_H_ACT + VGA_H_FP;

    localparam int unsigned VGA_V_SYNC = 4;
    localparam int unsigned VGA_V_BP   = 23;
    localparam int unsigned VGA_V_ACT  = 600;
    localparam int unsigned VGA_V_FP   = 1;
    localparam int unsigned VGA_V_TOT  = VGA_V_SYNC + VGA_V_BP + VGA_V_ACT + VGA_V_FP;

    localparam logic VGA_H_POL = 1'b1;
    localparam logic VGA_V_POL = 1'b1;

    // Window bounds shared with pattern generators (first visible column/row, one past last)
    localparam int unsigned VGA_H_ACT_FIRST = VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_H_ACT_END   = VGA_H_ACT_FIRST + VGA_H_ACT;
    localparam int unsigned VGA_V_ACT_FIRST = VGA_V_SYNC + VGA_V_BP;
    localparam int unsigned VGA_V_ACT_END   = VGA_V_ACT_FIRST + VGA_V_ACT;

endpackage

// File: rtl/vga_sync_axis.sv
// rtl/vga_sync_axis.sv - one raster axis: wrapping counter, sync and window decode
module vga_sync_axis
    import vga_timing_pkg::*;
#(
    parameter int unsigned SYNC = 128,
    parameter int unsigned BP   = 88,
    parameter int unsigned ACT  = 800,
    parameter int unsigned FP   = 40,
    parameter logic        POL  = 1'b1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output coord_t cnt,
    output logic   sync,
    output logic   active_nxt,
    output logic   wrap
);

    localparam int unsigned TOT = SYNC + BP + ACT + FP;

    if (TOT >= 2048 || TOT == 0) begin : g_bad_params
        $error("vga_sync_axis: axis total must be 1..2047");
    end

    localparam coord_t LAST     = coord_t'(TOT - 1);
    localparam coord_t SYNC_END = coord_t'(SYNC);
    localparam coord_t ACT_LO   = coord_t'(SYNC + BP);
    localparam coord_t ACT_HI   = coord_t'(SYNC + BP + ACT);

    coord_t cnt_nxt;

    // Decode from the next count so registered outputs move on the same edge as cnt
    always_comb begin
        wrap    = en && (cnt == LAST);
        cnt_nxt = cnt;
        if (wrap) begin
            cnt_nxt = '0;
        end else if (en) begin
            cnt_nxt = cnt + coord_t'(1);
        end
        active_nxt = (cnt_nxt >= ACT_LO) && (cnt_nxt < ACT_HI);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            sync <= POL;
        end else begin
            cnt  <= cnt_nxt;
            sync <= (cnt_nxt < SYNC_END) ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running VGA raster timing generator; optional frame_cnt via VGA_TIMING_FRAME_CNT_EN
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1,
    parameter int unsigned H_SYNC  = VGA_H_SYNC,
    parameter int unsigned H_BP    = VGA_H_BP,
    parameter int unsigned H_ACT   = VGA_H_ACT,
    parameter int unsigned H_FP    = VGA_H_FP,
    parameter int unsigned V_SYNC  = VGA_V_SYNC,
    parameter int unsigned V_BP    = VGA_V_BP,
    parameter int unsigned V_ACT   = VGA_V_ACT,
    parameter int unsigned V_FP    = VGA_V_FP,
    parameter logic        H_POL   = VGA_H_POL,
    parameter logic        V_POL   = VGA_V_POL
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] hc,
    output logic [10:0] vc,
    output logic        hsync,
    output logic        vsync,
    output logic        vidon,
    output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    if (CLK_DIV == 0) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             line_end;
    logic             v_en;
    logic             frame_wrap;
    logic             h_act_nxt;
    logic             v_act_nxt;

    assign tick = (div_cnt == DIV_LAST);
    assign v_en = tick & line_end;

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    vga_sync_axis #(
        .SYNC (H_SYNC),
        .BP   (H_BP),
        .ACT  (H_ACT),
        .FP   (H_FP),
        .POL  (H_POL)
    ) u_h_axis (
        .clk        (clk),
        .rst        (rst),
        .en         (tick),
        .cnt        (hc),
        .sync       (hsync),
        .active_nxt (h_act_nxt),
        .wrap       (line_end)
    );

    vga_sync_axis #(
        .SYNC (V_SYNC),
        .BP   (V_BP),
        .ACT  (V_ACT),
        .FP   (V_FP),
        .POL  (V_POL)
    ) u_v_axis (
        .clk        (clk),
        .rst        (rst),
        .en         (v_en),
        .cnt        (vc),
        .sync       (vsync),
        .active_nxt (v_act_nxt),
        .wrap       (frame_wrap)
    );

    // frame_wrap is only true on the last pixel's tick, so frame_start is a single-clk pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            vidon       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vidon       <= h_act_nxt & v_act_nxt;
            frame_start <= frame_wrap;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running VGA raster timing generator for the 800x600@60 Hz mode, and the source end of the pixel-coordinate interface. It derives a pixel tick from the system clock and advances horizontal and vertical counters. From those counters it produces `hsync`, `vsync`, `vidon`, `hc` and `vc`. Pattern and shape generators consume `hc`/`vc`/`vidon` combinationally; `hsync`/`vsync` go straight to the board connector.

## Interface
Parameters:
- `CLK_DIV`, 1 — system clocks per pixel; 1 means `clk` is the 40 MHz pixel clock.
- `H_SYNC`, 128 — hsync width in pixels.
- `H_BP`, 88 — horizontal back porch.
- `H_ACT`, 800 — visible pixels per line.
- `H_FP`, 40 — horizontal front porch.
- `V_SYNC`, 4 — vsync width in lines.
- `V_BP`, 23 — vertical back porch.
- `V_ACT`, 600 — visible lines.
- `V_FP`, 1 — vertical front porch.
- `H_POL`, 1 — level of `hsync` during sync (1 = active-high).
- `V_POL`, 1 — level of `vsync` during sync.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1 — system clock.
- `rst` in 1 — synchronous reset, active-high.
- `hc` out 11 — horizontal count, 0..H_TOT-1 (H_TOT = 1056).
- `vc` out 11 — vertical count, 0..V_TOT-1 (V_TOT = 628).
- `hsync` out 1 — horizontal sync.
- `vsync` out 1 — vertical sync.
- `vidon` out 1 — high while the counters are inside the visible window.
- `frame_start` out 1 — one-`clk` pulse when the counters wrap to (0,0).
- `frame_cnt` out 16 — frame counter; present only with `VGA_TIMING_FRAME_CNT_EN`.

## Operation
- **Prescaler:** `div_cnt` counts 0..CLK_DIV-1. `tick` = (`div_cnt` == CLK_DIV-1). With CLK_DIV = 1, `tick` is high every cycle.
- **Horizontal counter:** on `tick`, `hc` increments. At H_TOT-1 it wraps to 0 and produces `line_end`.
- **Vertical counter:** on `tick & line_end`, `vc` increments. At V_TOT-1 it wraps to 0.
- **Line layout:** each line is sync, then back porch, then active, then front porch. hsync region is `hc` 0..127. Visible region is `hc` 216..1015.
- **Frame layout:** vsync region is `vc` 0..3. Visible region is `vc` 27..626.
- **`vidon`:** equals (H_SYNC+H_BP ≤ hc < H_SYNC+H_BP+H_ACT) and (V_SYNC+V_BP ≤ vc < V_SYNC+V_BP+V_ACT).
- **Sync outputs:** `hsync` = H_POL while hc < H_SYNC, else ~H_POL. `vsync` is the same rule using `vc`, V_SYNC and V_POL.
- **Output registers:** `hsync`, `vsync` and `vidon` are registered. They are decoded from the next-count values, so every output changes on the same edge as `hc`/`vc`, with no decode glitches.
- **`frame_start`:** registered. It is high for the single `clk` cycle in which `hc`/`vc` first read (0,0) after a wrap. It is not asserted by reset.
- **Widths:** all counters and compares are unsigned 11-bit. Parameter sums must stay below 2048; elaboration fails otherwise.

## Timing
- **Reset state:** `div_cnt` = 0, `hc` = 0, `vc` = 0, `hsync` = H_POL, `vsync` = V_POL, `vidon` = 0, `frame_start` = 0, `frame_cnt` = 0.
- **Reset priority:** `rst` overrides `tick` in the same cycle. Asserting reset mid-line restarts the raster at (0,0) on the next edge; no partial-frame state is kept.
- **Latency:** the first `tick` arrives CLK_DIV cycles after reset release. `hc` and `vidon` update on that same edge.
- **Frame length:** H_TOT × V_TOT × CLK_DIV clocks = 663 168 clocks with the defaults.
- **Simultaneous wraps:** the last pixel of a frame wraps `hc`, wraps `vc` and raises `frame_start`, all on one edge.
- **Between ticks:** outputs hold their values for CLK_DIV-1 cycles.

## Configuration
- **`VGA_TIMING_FRAME_CNT_EN` defined:** port `frame_cnt` exists. It increments by 1 in the cycle `frame_start` is registered high, and wraps from 0xFFFF to 0. It is cleared by `rst`.
- **Macro undefined:** neither the port nor its register exists. All other behaviour is identical.

## Structure
- **Shared package `vga_timing_pkg`:** holds the 800x600@60 constants (sync, porch and active widths, H_TOT, V_TOT, polarities) and the 11-bit coordinate typedef. Pattern generators import the same package for window bounds (e.g. first visible column 216).
- **Sub-module `vga_sync_axis`:** one counter with wrap, sync decode and active-window decode. It is instantiated once for the horizontal axis and once for the vertical axis. The vertical instance is enabled by `tick & line_end`.

## Test plan
- Reset release with CLK_DIV=1 → `hc` reads 0,1,2… on consecutive cycles. `hsync`=1 for hc 0..127 and 0 at hc=128. `vidon` first goes high at hc=216, vc=27.
- Run a full line → `hc` wraps 1055→0 and `vc` goes 0→1 on the same edge. `vidon` falls at hc=1016.
- Run a full frame → `frame_start` pulses exactly once, after 663 168 clocks. `vsync` is high for vc 0..3.
- CLK_DIV=4 → each `hc` value holds 4 clocks, and the frame lasts 2 652 672 clocks.
- Assert `rst` for 1 cycle at hc=500, vc=300 → the next cycle shows hc=0, vc=0, `vidon`=0, `frame_start`=0.
- With `VGA_TIMING_FRAME_CNT_EN`: run 3 frames → `frame_cnt` reads 3. Force the counter to 0xFFFF, run one more frame → `frame_cnt` reads 0.
